d_mem_arbiter: RTL and testbench
================================

D_MEM_ARBITER -- requirements
Module: d_mem_arbiter

Interface
REQ-001 Parameter MEM_SIZE, default 1024: word depth of the attached d_mem; addresses are word indices.
REQ-002 clock  input  1  single system clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 m0_req  input  1  requester 0 access request; held with its qualifiers until m0_gnt.
REQ-005 m0_we  input  1  requester 0 write (1) / read (0).
REQ-006 m0_addr  input  32  requester 0 word address.
REQ-007 m0_wdata  input  32  requester 0 write data.
REQ-008 m0_gnt  output  1  request accepted this cycle.
REQ-009 m0_rvalid  output  1  m0_rdata valid, one-cycle pulse.
REQ-010 m0_rdata  output  32  read data returned to requester 0.
REQ-011 m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same directions, widths and meanings as REQ-004..REQ-010, for requester 1.
REQ-012 mem_addr  output  32  to d_mem Address.
REQ-013 mem_wdata  output  32  to d_mem WriteData.
REQ-014 mem_we  output  1  to d_mem MemWrite.
REQ-015 mem_re  output  1  to d_mem MemRead.
REQ-016 mem_rdata  input  32  from d_mem ReadData, combinational.

Function
REQ-017 FSM states: IDLE, SERVE_M0, SERVE_M1.
REQ-018 Arbitration runs every cycle in every state; a requester wins when its req is high and the arbiter has not been reset in that cycle.
REQ-019 One requester active: it wins. Both active: the one not granted last wins (round-robin via a 1-bit last_grant register).
REQ-020 Winner's gnt is high combinationally in the arbitration cycle T; its addr, wdata and we are latched at the end of T; last_grant updates to the winner.
REQ-021 In cycle T+1 the state is SERVE_Mx; mem_addr = latched addr % MEM_SIZE; mem_wdata = latched wdata; mem_we = latched we; mem_re = ~latched we.
REQ-022 Read: mem_rdata is captured at the end of T+1; the winner's rvalid pulses high in T+2 with rdata holding the captured value.
REQ-023 rdata holds its value until that requester's next read completes.
REQ-024 Write: completion is signalled by gnt only; no rvalid pulse.
REQ-025 Next state: SERVE_Mx if there is a winner, otherwise IDLE. Back-to-back grants sustain one access per cycle.
REQ-026 IDLE: mem_we = 0 and mem_re = 0; mem_addr and mem_wdata hold their last values.
REQ-027 At most one gnt is high per cycle; at most one rvalid is high per cycle.
REQ-028 A requester whose req drops before gnt is dropped; no access is performed for it.

Reset
REQ-029 While reset is high: state goes to IDLE; last_grant goes to 1, so m0 wins the first tie; m0_rdata = m1_rdata = 0; all rvalid = 0; latched addr/wdata/we = 0.
REQ-030 While reset is high: gnt outputs, mem_we and mem_re are forced to 0 combinationally.
REQ-031 An access in SERVE_Mx during a reset cycle is aborted: no write occurs and no rvalid follows.
REQ-032 The first grant is possible in the first cycle after reset deasserts.

Structure
REQ-033 FSM state encodings and the requester-index constants (M0 = 0, M1 = 1) reside in the shared package d_mem_pkg; MEM_SIZE default is also exported from it.
REQ-034 The round-robin pick logic is the sub-module rr_arb2 (inputs req[1:0], last_grant; output one-hot grant).
REQ-035 d_mem is instantiated by the parent, not inside this block.

Verification
REQ-036 Single read: reset, mem[5] = 0xDEADBEEF, m0 read addr 5 at T -> m0_gnt at T, mem_re = 1 and mem_addr = 5 at T+1, m0_rvalid = 1 and m0_rdata = 0xDEADBEEF at T+2.
REQ-037 Write then read: m1 writes 0x12345678 to addr 7, then m1 reads addr 7 -> mem_we = 1 for exactly one cycle; the read returns 0x12345678 with m1_rvalid.
REQ-038 Contention: m0 and m1 both hold req for 4 cycles after reset -> grants alternate m0, m1, m0, m1; never both in one cycle.
REQ-039 Wrap-around: m0 reads addr 1029 with MEM_SIZE = 1024 -> mem_addr = 5.
REQ-040 Reset mid-operation: m0 write granted at T, reset high in T+1 -> mem_we = 0 in T+1, no later rvalid, rdata = 0, next tie goes to m0.
REQ-041 Back-to-back: m0 issues reads to addr 1, 2, 3 in consecutive cycles with m1 idle -> three consecutive rvalid pulses in order.

Source files
------------

// File: rtl/d_mem_pkg.sv
// Shared types and constants for the two-requester data-memory arbiter.
package d_mem_pkg;

  localparam int unsigned MEM_SIZE_DEFAULT = 1024;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SERVE_M0 = 2'd1,
    SERVE_M1 = 2'd2
  } state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } access_t;

endpackage

// File: rtl/d_mem_arbiter_if.sv
// Requester and memory-side signal bundle; the arbiter uses the slave modport.
interface d_mem_arbiter_if;

  logic        m0_req;
  logic        m0_we;
  logic [31:0] m0_addr;
  logic [31:0] m0_wdata;
  logic        m0_gnt;
  logic        m0_rvalid;
  logic [31:0] m0_rdata;

  logic        m1_req;
  logic        m1_we;
  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  logic        m1_gnt;
  logic        m1_rvalid;
  logic [31:0] m1_rdata;

  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [31:0] mem_rdata;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    output m0_gnt, m0_rvalid, m0_rdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m1_gnt, m1_rvalid, m1_rdata,
    output mem_addr, mem_wdata, mem_we, mem_re,
    input  mem_rdata
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    input  m0_gnt, m0_rvalid, m0_rdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  mem_addr, mem_wdata, mem_we, mem_re,
    output mem_rdata
  );

endinterface

// File: rtl/d_mem_arbiter_rr_arb2.sv
// Two-way round-robin pick: a tie goes to the requester not granted last.
module rr_arb2
  import d_mem_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = '0;
    unique case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last_grant == M1) ? 2'b01 : 2'b10;
      default: grant = '0;
    endcase
  end

endmodule

// File: rtl/d_mem_arbiter.sv
// Arbitrates two requesters onto one single-cycle d_mem port, one access per cycle.
module d_mem_arbiter
  import d_mem_pkg::*;
#(
  parameter int unsigned MEM_SIZE = MEM_SIZE_DEFAULT
) (
  input  logic           clock,
  input  logic           reset,
  d_mem_arbiter_if.slave bus
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_last_grant;
  access_t     r_acc;
  logic [1:0]  r_rvalid;
  logic [31:0] r_rdata0;
  logic [31:0] r_rdata1;

  logic [1:0]  w_req;
  logic [1:0]  w_grant;
  logic        w_serving;
  logic        w_who;

  // Masking requests with reset also forces both gnt outputs low during reset.
  assign w_req = {bus.m1_req, bus.m0_req} & {2{~reset}};

  rr_arb2 u_rr_arb2 (
    .req        (w_req),
    .last_grant (r_last_grant),
    .grant      (w_grant)
  );

  assign bus.m0_gnt    = w_grant[0];
  assign bus.m1_gnt    = w_grant[1];
  assign bus.m0_rvalid = r_rvalid[0];
  assign bus.m1_rvalid = r_rvalid[1];
  assign bus.m0_rdata  = r_rdata0;
  assign bus.m1_rdata  = r_rdata1;

  // Latched address/data only change on a grant, so they hold through IDLE.
  assign bus.mem_addr  = r_acc.addr % MEM_SIZE;
  assign bus.mem_wdata = r_acc.wdata;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = IDLE;
    w_serving   = 1'b0;
    w_who       = M0;
    bus.mem_we  = 1'b0;
    bus.mem_re  = 1'b0;

    if (w_grant[0]) begin
      w_state_nxt = SERVE_M0;
    end else if (w_grant[1]) begin
      w_state_nxt = SERVE_M1;
    end

    unique case (r_state)
      SERVE_M0: begin
        w_serving = ~reset;
        w_who     = M0;
      end
      SERVE_M1: begin
        w_serving = ~reset;
        w_who     = M1;
      end
      default: begin
        w_serving = 1'b0;
        w_who     = M0;
      end
    endcase

    if (w_serving) begin
      bus.mem_we = r_acc.we;
      bus.mem_re = ~r_acc.we;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_last_grant <= M1;
      r_acc        <= '0;
      r_rvalid     <= '0;
      r_rdata0     <= '0;
      r_rdata1     <= '0;
    end else begin
      r_rvalid <= '0;
      if (w_grant[1]) begin
        r_last_grant <= M1;
        r_acc        <= '{we: bus.m1_we, addr: bus.m1_addr, wdata: bus.m1_wdata};
      end else if (w_grant[0]) begin
        r_last_grant <= M0;
        r_acc        <= '{we: bus.m0_we, addr: bus.m0_addr, wdata: bus.m0_wdata};
      end
      if (w_serving && !r_acc.we) begin
        r_rvalid[w_who] <= 1'b1;
        if (w_who == M1) begin
          r_rdata1 <= bus.mem_rdata;
        end else begin
          r_rdata0 <= bus.mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_d_mem_arbiter.sv
// Directed bench for d_mem_arbiter with a transaction-level reference model.
module tb_d_mem_arbiter;
  import d_mem_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  d_mem_arbiter_if bus ();

  d_mem_arbiter #(.MEM_SIZE(1024)) dut (
    .clock (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] mem [1024];
  assign bus.mem_rdata = mem[bus.mem_addr[9:0]];
  always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr[9:0]] <= bus.mem_wdata;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an accepted access occupies the memory bus the next
  // cycle; a read's data is returned to its owner one cycle after that.
  logic [31:0] ref_mem [1024];
  bit          model_ok = 0;
  bit          p_v, p_who, p_we;
  logic [31:0] p_addr, p_wdata;
  bit          ret_v, ret_who;
  logic [31:0] m_rd [2];
  bit          m_last;
  logic [31:0] m_addr_hold, m_wdata_hold;

  always @(negedge clk) begin
    logic [1:0] eg;
    eg = 2'b00;
    if (!reset) begin
      if (bus.m0_req && bus.m1_req) eg = m_last ? 2'b01 : 2'b10;
      else eg = {bus.m1_req, bus.m0_req};
    end
    if (model_ok) begin
      chk("m0_gnt", {31'b0, bus.m0_gnt}, {31'b0, eg[0]});
      chk("m1_gnt", {31'b0, bus.m1_gnt}, {31'b0, eg[1]});
      chk("mem_we", {31'b0, bus.mem_we}, {31'b0, p_v && p_we && !reset});
      chk("mem_re", {31'b0, bus.mem_re}, {31'b0, p_v && !p_we && !reset});
      chk("mem_addr", bus.mem_addr, m_addr_hold);
      chk("mem_wdata", bus.mem_wdata, m_wdata_hold);
      chk("m0_rvalid", {31'b0, bus.m0_rvalid}, {31'b0, ret_v && !ret_who});
      chk("m1_rvalid", {31'b0, bus.m1_rvalid}, {31'b0, ret_v && ret_who});
      chk("m0_rdata", bus.m0_rdata, m_rd[0]);
      chk("m1_rdata", bus.m1_rdata, m_rd[1]);
    end
    if (reset) begin
      p_v = 0; ret_v = 0; ret_who = 0; p_we = 0; p_who = 0;
      m_rd[0] = '0; m_rd[1] = '0;
      m_last = 1; m_addr_hold = '0; m_wdata_hold = '0;
      model_ok = 1;
    end else begin
      ret_v   = p_v && !p_we;
      ret_who = p_who;
      if (p_v && !p_we) m_rd[p_who] = ref_mem[p_addr % 1024];
      if (p_v && p_we) ref_mem[p_addr % 1024] = p_wdata;
      p_v = |eg;
      if (p_v) begin
        p_who   = eg[1];
        p_we    = eg[1] ? bus.m1_we : bus.m0_we;
        p_addr  = eg[1] ? bus.m1_addr : bus.m0_addr;
        p_wdata = eg[1] ? bus.m1_wdata : bus.m0_wdata;
        m_last  = eg[1];
        m_addr_hold  = p_addr % 1024;
        m_wdata_hold = p_wdata;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv0(input bit req, input bit we, input logic [31:0] a, input logic [31:0] d);
    bus.m0_req = req; bus.m0_we = we; bus.m0_addr = a; bus.m0_wdata = d;
  endtask

  task automatic drv1(input bit req, input bit we, input logic [31:0] a, input logic [31:0] d);
    bus.m1_req = req; bus.m1_we = we; bus.m1_addr = a; bus.m1_wdata = d;
  endtask

  initial begin
    logic [1:0]  gseq [4];
    logic [31:0] rv_q [$];
    int          rv_c [$];
    int          we_cnt;

    for (int i = 0; i < 1024; i++) begin
      mem[i]     = 32'h1000_0000 + i;
      ref_mem[i] = 32'h1000_0000 + i;
    end
    mem[5] = 32'hDEAD_BEEF;
    ref_mem[5] = 32'hDEAD_BEEF;
    drv0(0, 0, '0, '0);
    drv1(0, 0, '0, '0);

    step(); step();
    // requests during reset must not be granted
    drv0(1, 0, 32'd9, '0); drv1(1, 0, 32'd9, '0);
    @(negedge clk);
    chk("rst_m0_gnt", {31'b0, bus.m0_gnt}, 32'd0);
    chk("rst_m1_gnt", {31'b0, bus.m1_gnt}, 32'd0);
    chk("rst_m0_rdata", bus.m0_rdata, 32'd0);
    chk("rst_rvalid", {30'b0, bus.m1_rvalid, bus.m0_rvalid}, 32'd0);

    // single read
    step(); reset = 0; drv0(1, 0, 32'd5, '0); drv1(0, 0, '0, '0);
    @(negedge clk); chk("rd_gnt", {31'b0, bus.m0_gnt}, 32'd1);
    step(); drv0(0, 0, '0, '0);
    @(negedge clk); chk("rd_mem_re", {31'b0, bus.mem_re}, 32'd1); chk("rd_mem_addr", bus.mem_addr, 32'd5);
    step();
    @(negedge clk); chk("rd_rvalid", {31'b0, bus.m0_rvalid}, 32'd1); chk("rd_rdata", bus.m0_rdata, 32'hDEAD_BEEF);

    // write then read, requester 1
    we_cnt = 0;
    step(); drv1(1, 1, 32'd7, 32'h1234_5678);
    @(negedge clk); chk("wr_gnt", {31'b0, bus.m1_gnt}, 32'd1); we_cnt += int'(bus.mem_we);
    step(); drv1(1, 0, 32'd7, '0);
    @(negedge clk); chk("wr_mem_we", {31'b0, bus.mem_we}, 32'd1); we_cnt += int'(bus.mem_we);
    step(); drv1(0, 0, '0, '0);
    @(negedge clk); chk("wr_rd_re", {31'b0, bus.mem_re}, 32'd1); we_cnt += int'(bus.mem_we);
    step();
    @(negedge clk); chk("wr_rd_rvalid", {31'b0, bus.m1_rvalid}, 32'd1);
    chk("wr_rd_rdata", bus.m1_rdata, 32'h1234_5678); we_cnt += int'(bus.mem_we);
    chk("wr_we_cycles", we_cnt, 32'd1);

    // contention right after reset
    step(); reset = 1;
    @(negedge clk);
    step(); reset = 0; drv0(1, 0, 32'd10, '0); drv1(1, 0, 32'd11, '0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); gseq[k] = {bus.m1_gnt, bus.m0_gnt};
      step();
    end
    drv0(0, 0, '0, '0); drv1(0, 0, '0, '0);
    chk("rr_g0", {30'b0, gseq[0]}, 32'd1);
    chk("rr_g1", {30'b0, gseq[1]}, 32'd2);
    chk("rr_g2", {30'b0, gseq[2]}, 32'd1);
    chk("rr_g3", {30'b0, gseq[3]}, 32'd2);
    step(); step();

    // address wrap-around
    drv0(1, 0, 32'd1029, '0);
    @(negedge clk); chk("wrap_gnt", {31'b0, bus.m0_gnt}, 32'd1);
    step(); drv0(0, 0, '0, '0);
    @(negedge clk); chk("wrap_addr", bus.mem_addr, 32'd5);
    step();
    @(negedge clk); chk("wrap_rdata", bus.m0_rdata, 32'hDEAD_BEEF);

    // tie goes to m1 (m0 was last); m0 then withdraws and is never served
    step(); drv0(1, 0, 32'd12, '0); drv1(1, 0, 32'd13, '0);
    @(negedge clk); chk("drop_m1_gnt", {30'b0, bus.m1_gnt, bus.m0_gnt}, 32'd2);
    step(); drv0(0, 0, '0, '0); drv1(0, 0, '0, '0);
    @(negedge clk); chk("drop_addr", bus.mem_addr, 32'd13);
    step(); step();

    // reset while a write is being served
    step(); drv0(1, 1, 32'd20, 32'hAAAA_5555);
    @(negedge clk); chk("rm_gnt", {31'b0, bus.m0_gnt}, 32'd1);
    step(); drv0(0, 0, '0, '0); reset = 1;
    @(negedge clk); chk("rm_mem_we", {31'b0, bus.mem_we}, 32'd0);
    step(); reset = 0; drv0(1, 0, 32'd20, '0); drv1(1, 0, 32'd7, '0);
    @(negedge clk);
    chk("rm_rvalid", {31'b0, bus.m0_rvalid}, 32'd0);
    chk("rm_rdata", bus.m0_rdata, 32'd0);
    chk("rm_tie", {30'b0, bus.m1_gnt, bus.m0_gnt}, 32'd1);
    step(); drv0(0, 0, '0, '0);
    @(negedge clk); chk("rm_m1_gnt", {31'b0, bus.m1_gnt}, 32'd1);
    step(); drv1(0, 0, '0, '0);
    @(negedge clk); chk("rm_old_data", bus.m0_rdata, 32'h1000_0014);
    step();
    @(negedge clk); chk("rm_m1_rdata", bus.m1_rdata, 32'h1234_5678);

    // back-to-back reads
    for (int k = 0; k < 6; k++) begin
      step();
      if (k < 3) drv0(1, 0, 32'(k + 1), '0);
      else drv0(0, 0, '0, '0);
      @(negedge clk);
      if (bus.m0_rvalid) begin
        rv_q.push_back(bus.m0_rdata);
        rv_c.push_back(k);
      end
    end
    chk("b2b_count", 32'(rv_q.size()), 32'd3);
    if (rv_q.size() == 3) begin
      chk("b2b_d0", rv_q[0], 32'h1000_0001);
      chk("b2b_d1", rv_q[1], 32'h1000_0002);
      chk("b2b_d2", rv_q[2], 32'h1000_0003);
      chk("b2b_span", 32'(rv_c[2] - rv_c[0]), 32'd2);
    end

    step(); step(); step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
